// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetches instruction words, evaluates the Cond
// field against the stored NZCV register and steps the ALU, data memory and write-back.
module instr_sequencer #(
    parameter int unsigned   AW     = 16,
    parameter int unsigned   DW     = 32,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [AW-1:0] counter,
    output logic          imem_en,
    input  logic          imem_valid,
    input  logic [DW-1:0] code_in,
    output logic [DW-1:0] code,
    output logic          alu_en,
    input  logic [3:0]    alu_nzcv,
    output logic          mem_en,
    output logic          mem_rw,
    input  logic          mem_ready,
    output logic          reg_we,
    output logic          ldr_sel,
    output logic [3:0]    flags,
    output logic          halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    localparam logic [3:0] OP_LDR  = 4'hA;
    localparam logic [3:0] OP_STR  = 4'hB;
    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] code_q, code_d;
    logic [3:0]    flags_q, flags_d;

    logic [3:0]    cond_f;
    logic [3:0]    op_f;
    logic          s_f;
    logic          is_ldr;
    logic          cond_ok;
    logic [AW-1:0] pc_inc;
    logic [AW-1:0] br_off;
    logic [AW-1:0] pc_br;

    assign cond_f = code_q[31:28];
    assign op_f   = code_q[27:24];
    assign s_f    = code_q[23];
    assign is_ldr = (op_f == OP_LDR);

    // Both PC updates wrap modulo 2^AW; the offset is sign-extended to AW bits.
    assign pc_inc = pc_q + AW'(1);
    assign br_off = AW'($signed(code_q[15:0]));
    assign pc_br  = pc_q + br_off;

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        logic r;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = cf;
            4'h3:    r = !cf;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = cf && !z;
            4'h9:    r = !cf || z;
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z && (n == v);
            4'hD:    r = z || (n != v);
            4'hE:    r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign cond_ok = cond_pass(cond_f, flags_q);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        code_d  = code_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_valid) begin
                    code_d  = code_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (!cond_ok) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end else begin
                    case (op_f)
                        OP_HALT: state_d = S_HALT;
                        OP_BR: begin
                            pc_d    = pc_br;
                            state_d = S_FETCH;
                        end
                        OP_LDR, OP_STR: state_d = S_MEM;
                        default:        state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC: begin
                if (s_f) flags_d = alu_nzcv;
                state_d = S_WB;
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (is_ldr) begin
                        state_d = S_WB;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_FETCH;
                    end
                end
            end
            S_WB: begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RST_PC;
            code_q  <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            code_q  <= code_d;
            flags_q <= flags_d;
        end
    end

    // Strobes decode straight from the state register so reset clears them without a clock.
    assign imem_en = (state_q == S_FETCH);
    assign alu_en  = (state_q == S_EXEC);
    assign mem_en  = (state_q == S_MEM);
    assign mem_rw  = (state_q == S_MEM) && is_ldr;
    assign reg_we  = (state_q == S_WB);
    assign ldr_sel = (state_q == S_WB) && is_ldr;
    assign halted  = (state_q == S_HALT);
    assign counter = pc_q;
    assign code    = code_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of single-instruction vectors run
// through a scoreboard, plus hand sequences for wait states, HALT and mid-access reset.
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] counter;
    logic        imem_en;
    logic        imem_valid;
    logic [31:0] code_in;
    logic [31:0] code;
    logic        alu_en;
    logic [3:0]  alu_nzcv;
    logic        mem_en;
    logic        mem_rw;
    logic        mem_ready;
    logic        reg_we;
    logic        ldr_sel;
    logic [3:0]  flags;
    logic        halted;

    int unsigned tests = 0;
    int unsigned fails = 0;

    instr_sequencer #(.AW(16), .DW(32), .RST_PC(16'h0000)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .counter   (counter),
        .imem_en   (imem_en),
        .imem_valid(imem_valid),
        .code_in   (code_in),
        .code      (code),
        .alu_en    (alu_en),
        .alu_nzcv  (alu_nzcv),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_ready (mem_ready),
        .reg_we    (reg_we),
        .ldr_sel   (ldr_sel),
        .flags     (flags),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  nzcv;
        int unsigned cycles;
        int unsigned alu_at;
        int unsigned we_at;
        int unsigned mem_n;
        logic        rw;
        logic        ldr;
        logic [15:0] pc;
        logic [3:0]  fl;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic vec_t mk(input logic [31:0] instr, input logic [3:0] nzcv,
                                input int unsigned cyc, input int unsigned alu_at,
                                input int unsigned we_at, input int unsigned mem_n,
                                input logic rw, input logic ldr,
                                input logic [15:0] pc, input logic [3:0] fl);
        vec_t v;
        v.instr = instr; v.nzcv = nzcv; v.cycles = cyc; v.alu_at = alu_at;
        v.we_at = we_at; v.mem_n = mem_n; v.rw = rw; v.ldr = ldr; v.pc = pc; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in FETCH; returns on the next FETCH (or HALT).
    task automatic run_instr(input vec_t v);
        vec_t        e;
        int unsigned n = 0, alu_n = 0, we_n = 0, mem_n = 0, alu_at = 0, we_at = 0;
        logic        rw = 1'b0, ldr = 1'b0;
        code_in    = v.instr;
        alu_nzcv   = v.nzcv;
        imem_valid = 1'b1;
        mem_ready  = 1'b1;
        sb.push_back(v);
        do begin
            n++;
            chk("one_strobe_group",
                32'($countones({imem_en, alu_en, mem_en, reg_we, halted}) <= 1), 1);
            if (alu_en) begin alu_n++; if (alu_at == 0) alu_at = n; end
            if (reg_we) begin we_n++;  if (we_at == 0)  we_at = n;  ldr = ldr | ldr_sel; end
            if (mem_en) begin mem_n++; rw = rw | mem_rw; end
            step();
        end while (!imem_en && !halted && n < 20);
        e = sb.pop_front();
        chk("instr_timeout", 32'(n < 20), 1);
        chk("instr_cycles", n, e.cycles);
        chk("alu_en_count", alu_n, (e.alu_at != 0) ? 1 : 0);
        chk("alu_en_cycle", alu_at, e.alu_at);
        chk("reg_we_count", we_n, (e.we_at != 0) ? 1 : 0);
        chk("reg_we_cycle", we_at, e.we_at);
        chk("mem_en_cycles", mem_n, e.mem_n);
        chk("mem_rw", rw, e.rw);
        chk("ldr_sel", ldr, e.ldr);
        chk("counter", counter, e.pc);
        chk("flags", flags, e.fl);
        chk("code_latched", code, e.instr);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_counter"}, counter, 0);
        chk({tag, "_code"}, code, 0);
        chk({tag, "_flags"}, flags, 0);
        chk({tag, "_strobes"},
            {imem_en, alu_en, mem_en, mem_rw, reg_we, ldr_sel, halted}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        reset = 1'b0; start = 1'b0; imem_valid = 1'b0; code_in = '0;
        alu_nzcv = '0; mem_ready = 1'b0;

        vecs.push_back(mk(32'hE1000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0001, 4'h0));
        vecs.push_back(mk(32'hE1800000, 4'h4, 4, 3, 4, 0, 0, 0, 16'h0002, 4'h4));
        vecs.push_back(mk(32'h01000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0003, 4'h4));
        vecs.push_back(mk(32'h11000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0004, 4'h4));
        vecs.push_back(mk(32'hEA000000, 4'hF, 4, 0, 4, 1, 1, 1, 16'h0005, 4'h4));
        vecs.push_back(mk(32'hEC00FFFE, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0003, 4'h4));
        vecs.push_back(mk(32'hEB000000, 4'hF, 3, 0, 0, 1, 0, 0, 16'h0004, 4'h4));
        vecs.push_back(mk(32'h81000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0005, 4'h4));
        vecs.push_back(mk(32'h91000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0006, 4'h4));
        vecs.push_back(mk(32'hF1000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0007, 4'h4));
        vecs.push_back(mk(32'hE1800000, 4'h9, 4, 3, 4, 0, 0, 0, 16'h0008, 4'h9));
        vecs.push_back(mk(32'hA1000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0009, 4'h9));
        vecs.push_back(mk(32'hB1000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h000A, 4'h9));
        vecs.push_back(mk(32'hC1800000, 4'h2, 4, 3, 4, 0, 0, 0, 16'h000B, 4'h2));
        vecs.push_back(mk(32'h21000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h000C, 4'h2));
        vecs.push_back(mk(32'h31000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h000D, 4'h2));
        vecs.push_back(mk(32'hEC000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h000D, 4'h2));
        vecs.push_back(mk(32'h0A000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h000E, 4'h2));
        vecs.push_back(mk(32'hEC00FFF0, 4'hF, 2, 0, 0, 0, 0, 0, 16'hFFFE, 4'h2));
        vecs.push_back(mk(32'hEC000004, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0002, 4'h2));
        vecs.push_back(mk(32'hEC00FFFD, 4'hF, 2, 0, 0, 0, 0, 0, 16'hFFFF, 4'h2));
        vecs.push_back(mk(32'hE1000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0000, 4'h2));
        vecs.push_back(mk(32'h1B000000, 4'hF, 3, 0, 0, 1, 0, 0, 16'h0001, 4'h2));
        vecs.push_back(mk(32'h41000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0002, 4'h2));
        vecs.push_back(mk(32'h51000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0003, 4'h2));
        vecs.push_back(mk(32'h61000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0004, 4'h2));
        vecs.push_back(mk(32'h71000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0005, 4'h2));
        vecs.push_back(mk(32'hD1000000, 4'hF, 2, 0, 0, 0, 0, 0, 16'h0006, 4'h2));

        // Reset and IDLE
        repeat (2) step();
        chk_reset_outputs("reset");
        reset = 1'b1;
        imem_valid = 1'b1;
        mem_ready = 1'b1;
        repeat (2) step();
        chk("idle_no_fetch", imem_en, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_fetch", imem_en, 1);
        chk("start_pc", counter, 16'h0000);

        foreach (vecs[i]) run_instr(vecs[i]);

        // LDR with a two-cycle fetch stall and mem_ready after three wait cycles
        code_in = 32'hEA000000;
        imem_valid = 1'b0;
        mem_ready = 1'b0;
        alu_nzcv = 4'hF;
        repeat (2) begin
            step();
            chk("fetch_hold_en", imem_en, 1);
            chk("fetch_hold_pc", counter, 16'h0006);
        end
        imem_valid = 1'b1;
        step();
        chk("ldr_decode_quiet", {imem_en, mem_en, alu_en, reg_we}, 0);
        step();
        n = 0;
        start = 1'b1;
        while (mem_en && n < 10) begin
            n++;
            chk("ldr_wait_rw", mem_rw, 1);
            if (n == 4) mem_ready = 1'b1;
            step();
        end
        start = 1'b0;
        chk("ldr_wait_cycles", n, 4);
        chk("ldr_wb_we", reg_we, 1);
        chk("ldr_wb_sel", ldr_sel, 1);
        chk("ldr_wb_mem_off", mem_en, 0);
        step();
        chk("ldr_next_fetch", imem_en, 1);
        chk("ldr_next_pc", counter, 16'h0007);
        chk("ldr_flags", flags, 4'h2);

        // HALT: frozen until start, then resume at counter+1
        code_in = 32'hEF000000;
        step();
        step();
        chk("halt_entered", halted, 1);
        for (int i = 0; i < 10; i++) begin
            imem_valid = 1'($urandom_range(0, 1));
            step();
            chk("halt_held", halted, 1);
            chk("halt_pc", counter, 16'h0007);
            chk("halt_no_fetch", imem_en, 0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("halt_resume_fetch", imem_en, 1);
        chk("halt_resume_flag", halted, 0);
        chk("halt_resume_pc", counter, 16'h0008);
        run_instr(mk(32'hE1000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0009, 4'h2));

        // Reset asserted during a held data-memory access
        code_in = 32'hEA000000;
        mem_ready = 1'b0;
        step();
        step();
        chk("mem_before_reset", mem_en, 1);
        #3;
        reset = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        step();
        reset = 1'b1;
        repeat (2) step();
        chk("post_reset_idle", imem_en, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        mem_ready = 1'b1;
        chk("post_reset_fetch", imem_en, 1);
        run_instr(mk(32'hE1000000, 4'hF, 4, 3, 4, 0, 0, 0, 16'h0001, 4'h0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
